// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage between the program-counter stage and decode.
// Keeps a sequential fetch address, issues requests to instruction memory over
// a req/gnt/rvalid handshake and buffers returned words, together with their
// PCs, in a small FIFO that decode drains under valid/ready. A redirect flushes
// the buffer, restarts fetch at the new address and marks every in-flight
// response as stale so it is dropped on return.
//
// Optional feature macro: IF_FETCH_PERF_EN
//   When defined, adds stall_cnt_o, a saturating count of cycles where decode
//   was ready but no instruction was available.
//
// Ports
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   synchronous active-high reset
//   redirect_i     in   1   pulse: restart fetch at redirect_pc_i
//   redirect_pc_i  in   32  new fetch address (low 2 bits ignored)
//   imem_req_o     out  1   request valid to instruction memory
//   imem_addr_o    out  32  request address (current fetch PC)
//   imem_gnt_i     in   1   request accepted this cycle
//   imem_rvalid_i  in   1   read data valid, in order, one per grant
//   imem_rdata_i   in   32  instruction word
//   id_valid_o     out  1   buffer head valid to decode
//   id_ready_i     in   1   decode accepts head
//   id_instr_o     out  32  head instruction
//   id_pc_o        out  32  head instruction PC
//   stall_cnt_o    out  32  decode-starved cycle count (IF_FETCH_PERF_EN only)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR      = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [31:0]      r_instr [FIFO_DEPTH];
    logic [31:0]      r_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] r_discard;

    logic [CNT_W-1:0] w_count_d;
    logic [OUT_W-1:0] w_outstanding_d;
    logic [OUT_W-1:0] w_discard_d;
    logic             w_credit;
    logic             w_grant;
    logic             w_rvalid;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_redirect_pc;

    // Credit covers both the outstanding limit and a reserved FIFO slot for
    // every in-flight request, so a returning word can always be pushed.
    assign w_credit = (32'(r_outstanding) < MAX_OUTSTANDING) &&
                      ((32'(r_count) + 32'(r_outstanding)) < FIFO_DEPTH);

    assign imem_req_o    = !rst && !redirect_i && w_credit;
    assign imem_addr_o   = r_fetch_pc;
    assign w_grant       = imem_req_o && imem_gnt_i;
    // An rvalid with nothing outstanding is a protocol error and is ignored.
    assign w_rvalid      = imem_rvalid_i && (r_outstanding != '0);
    assign w_push        = w_rvalid && (r_discard == '0) && !redirect_i;
    assign w_pop         = id_valid_o && id_ready_i;
    assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

    assign id_valid_o = (r_count != '0);
    assign id_instr_o = r_instr[r_rptr];
    assign id_pc_o    = r_pc[r_rptr];

    always_comb begin
        w_outstanding_d = r_outstanding;
        if (w_grant && !w_rvalid) begin
            w_outstanding_d = r_outstanding + OUT_W'(1);
        end else if (!w_grant && w_rvalid) begin
            w_outstanding_d = r_outstanding - OUT_W'(1);
        end
    end

    always_comb begin
        w_discard_d = r_discard;
        if (redirect_i) begin
            // Everything still in flight after this cycle's return is stale;
            // r_outstanding already includes any earlier stale requests.
            w_discard_d = r_outstanding - OUT_W'(w_rvalid);
        end else if (w_rvalid && (r_discard != '0)) begin
            w_discard_d = r_discard - OUT_W'(1);
        end
    end

    always_comb begin
        w_count_d = r_count;
        if (redirect_i) begin
            w_count_d = '0;
        end else if (w_push && !w_pop) begin
            w_count_d = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_ADDR;
            r_resp_pc     <= RESET_ADDR;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_count       <= w_count_d;
            r_outstanding <= w_outstanding_d;
            r_discard     <= w_discard_d;
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wptr    <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_instr[r_wptr] <= imem_rdata_i;
            r_pc[r_wptr]    <= r_resp_pc;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (id_ready_i && !id_valid_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid_i && (r_outstanding == '0)))
                else $error("if_fetch_unit: rvalid with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] m_stall;
`endif

    if_fetch_unit #(
        .FIFO_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_ADDR     (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o)
`ifdef IF_FETCH_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t mem_q[$];   // requests granted by the memory model, awaiting rvalid
    exp_t  exp_q[$];   // scoreboard: entries decode must see, in order

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          epoch    = 0;
    int          m_out    = 0;
    int          m_fifo   = 0;
    int          n_pops   = 0;
    logic        gnt_en;
    logic        rdy_en;
    logic [31:0] model_pc;
    logic        last_valid;
    logic        last_req;
    logic [31:0] last_addr;
    logic [31:0] last_pop_pc;
    logic [31:0] last_pop_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory/decode inputs, check outputs at negedge,
    // advance the reference model, then step past the rising edge.
    task automatic run_cycle();
        mreq_t ent;
        exp_t  e;
        logic  rv;
        logic  exp_req;
        logic  exp_valid;
        logic  pop;
        logic  gnt;
        logic  acc;
        rv  = 1'b0;
        ent = '{addr: 32'h0, due: 0, ep: 0};
        if (!rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
            ent = mem_q.pop_front();
            rv  = 1'b1;
        end
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(ent.addr) : 32'h0;
        imem_gnt_i    = gnt_en;
        id_ready_i    = rdy_en;
        @(negedge clk);
        exp_req   = !rst && !redirect_i && (m_out < MAXO) && ((m_fifo + m_out) < DEPTH);
        exp_valid = (m_fifo != 0);
        check("imem_req", 32'(imem_req_o), 32'(exp_req));
        check("id_valid", 32'(id_valid_o), 32'(exp_valid));
`ifdef IF_FETCH_PERF_EN
        check("stall_cnt", stall_cnt_o, m_stall);
        if (rst) m_stall = 32'h0;
        else if (rdy_en && !exp_valid && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
`endif
        last_valid = id_valid_o;
        last_req   = imem_req_o;
        last_addr  = imem_addr_o;
        pop = exp_valid && rdy_en;
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("sb_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc_o, e.pc);
                check("id_instr", id_instr_o, e.instr);
            end
            n_pops++;
            last_pop_pc    = id_pc_o;
            last_pop_instr = id_instr_o;
        end
        gnt = exp_req && gnt_en;
        if (gnt) begin
            check("imem_addr", imem_addr_o, model_pc);
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            mem_q.push_back('{addr: imem_addr_o, due: cyc + lat, ep: epoch});
            model_pc = model_pc + 32'd4;
        end
        acc = rv && (ent.ep == epoch) && !redirect_i;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            m_out    = 0;
            m_fifo   = 0;
            model_pc = RST_PC;
            epoch++;
        end else begin
            m_out  = m_out + int'(gnt) - int'(rv);
            m_fifo = redirect_i ? 0 : (m_fifo + int'(acc) - int'(pop));
            if (redirect_i) begin
                exp_q.delete();
                epoch++;
                model_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int first_v;
        int pre;
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_ready_i    = 1'b0;
        gnt_en        = 1'b0;
        rdy_en        = 1'b0;
        model_pc      = RST_PC;
        last_pop_pc   = 32'h0;
        last_pop_instr = 32'h0;
`ifdef IF_FETCH_PERF_EN
        m_stall = 32'h0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        run_cycle();
        check("rst_instr", id_instr_o, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_valid", 32'(id_valid_o), 32'd0);

        // Streaming: gnt always, rvalid one cycle later, decode always ready
        rst    = 1'b0;
        gnt_en = 1'b1;
        rdy_en = 1'b1;
        lat    = 1;
        first_v = -1;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (last_valid && (first_v < 0)) first_v = i;
        end
        check("first_valid_latency", 32'(first_v), 32'd2);
        repeat (8) run_cycle();

        // Decode stalled: buffer fills, request drops, then drain and refill
        rdy_en = 1'b0;
        repeat (10) run_cycle();
        check("fill_req_dropped", 32'(last_req), 32'd0);
        check("fill_valid", 32'(last_valid), 32'd1);
        rdy_en = 1'b1;
        repeat (12) run_cycle();

        // Redirect with both requests outstanding
        lat = 4;
        repeat (6) run_cycle();
        for (int i = 0; (i < 10) && (m_out != MAXO); i++) run_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        run_cycle();
        redirect_i = 1'b0;
        check("redir_flush_valid", 32'(id_valid_o), 32'd0);
        pre = n_pops;
        for (int i = 0; (i < 30) && (n_pops == pre); i++) run_cycle();
        check("redir_popped", 32'(n_pops - pre), 32'd1);
        check("redir_first_pc", last_pop_pc, 32'h100);
        check("redir_first_instr", last_pop_instr, mem_word(32'h100));
        repeat (6) run_cycle();

        // Redirect coincident with rvalid and a pop; misaligned target
        lat = 1;
        repeat (8) run_cycle();
        pre = n_pops;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        run_cycle();
        redirect_i = 1'b0;
        check("coinc_pop_delivered", 32'(n_pops - pre), 32'd1);
        check("coinc_empty", 32'(id_valid_o), 32'd0);
        check("coinc_aligned_addr", imem_addr_o, 32'h200);
        pre = n_pops;
        for (int i = 0; (i < 20) && (n_pops == pre); i++) run_cycle();
        check("coinc_first_pc", last_pop_pc, 32'h200);
        repeat (4) run_cycle();

        // Address wrap and held-off grant
        gnt_en        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        run_cycle();
        redirect_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            check("wrap_hold_req", 32'(last_req), 32'd1);
            check("wrap_hold_addr", last_addr, 32'hFFFF_FFFC);
        end
        gnt_en = 1'b1;
        run_cycle();
        check("wrap_addr", imem_addr_o, 32'h0);
        repeat (10) run_cycle();

        // Reset in the middle of traffic
        lat = 2;
        repeat (5) run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        check("mid_rst_valid", 32'(id_valid_o), 32'd0);
        check("mid_rst_addr", imem_addr_o, RST_PC);
        check("mid_rst_pc", id_pc_o, 32'h0);
        repeat (10) run_cycle();

        // Slow memory with decode always ready (starved cycles)
        lat = 3;
        repeat (20) run_cycle();

        // Random traffic with occasional redirects
        for (int i = 0; i < 300; i++) begin
            gnt_en = 1'($urandom_range(0, 3) != 0);
            rdy_en = 1'($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom;
            end
            run_cycle();
            redirect_i = 1'b0;
        end

        // Drain
        gnt_en = 1'b0;
        rdy_en = 1'b1;
        repeat (15) run_cycle();
        check("drain_valid", 32'(id_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
